// File: rtl/mem_arbiter.sv
// Multi-channel arbiter sharing one asynchronous SRAM port.
// Round-robin or fixed-priority selection; one access per grant with a programmable strobe width.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | bus released, strobes high; arbitrate among requesters
// S_SETUP  | chip enabled, address (and write data) presented
// S_ACCESS | OE or WE low for WAIT_CYC cycles, timed by a down-counter
// S_DONE   | strobes released, work_done pulse to the owner
module mem_arbiter #(
    parameter int NCH       = 3,
    parameter int AW        = 18,
    parameter int DW        = 16,
    parameter int WAIT_CYC  = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    need_to_work,
    input  logic [NCH-1:0]    mem_wr,
    input  logic [NCH*AW-1:0] mem_addr,
    input  logic [NCH*DW-1:0] mem_value,
    output logic [NCH-1:0]    work_done,
    output logic [DW-1:0]     result,
    output logic [NCH-1:0]    grant,
    output logic              busy,
    output logic [AW-1:0]     Ram_Addr,
    inout  wire  [DW-1:0]     Ram_Data,
    output logic              Ram_EN,
    output logic              Ram_OE,
    output logic              Ram_WE
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic [NCH-1:0]  work_done_q, work_done_d;
    logic [DW-1:0]   result_q, result_d;
    logic            busy_q, busy_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic            drv_q, drv_d;
    logic            en_q, en_d;
    logic            oe_q, oe_d;
    logic            we_q, we_d;

    logic            found;
    logic [PW-1:0]   win_idx;
    logic [NCH-1:0]  win_oh;

    // Search starts at ptr in round-robin mode, at channel 0 in fixed mode.
    always_comb begin
        int j;
        j       = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            j = (PRIO_MODE != 0) ? i : int'(ptr_q) + i;
            if (j >= NCH) j = j - NCH;
            if (!found && need_to_work[PW'(j)]) begin
                found   = 1'b1;
                win_idx = PW'(j);
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = found;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        work_done_d = '0;
        result_d    = result_q;
        busy_d      = busy_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        drv_d       = drv_q;
        en_d        = en_q;
        oe_d        = oe_q;
        we_d        = we_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_SETUP;
                    grant_d = win_oh;
                    addr_d  = mem_addr[int'(win_idx)*AW +: AW];
                    wdata_d = mem_value[int'(win_idx)*DW +: DW];
                    wr_d    = mem_wr[win_idx];
                    drv_d   = mem_wr[win_idx];
                    ptr_d   = (win_idx == PW'(NCH - 1)) ? '0 : win_idx + 1'b1;
                    busy_d  = 1'b1;
                    en_d    = 1'b0;
                    oe_d    = 1'b1;
                    we_d    = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = 4'(WAIT_CYC - 1);
                oe_d    = wr_q;
                we_d    = ~wr_q;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d     = S_DONE;
                    en_d        = 1'b1;
                    oe_d        = 1'b1;
                    we_d        = 1'b1;
                    drv_d       = 1'b0;
                    work_done_d = grant_q;
                    // OE is still low on this edge, so the SRAM output is valid.
                    if (!wr_q) result_d = Ram_Data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            work_done_q <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            drv_q       <= 1'b0;
            en_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            work_done_q <= work_done_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            drv_q       <= drv_d;
            en_q        <= en_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
        end
    end

    assign work_done = work_done_q;
    assign result    = result_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign Ram_Addr  = addr_q;
    assign Ram_EN    = en_q;
    assign Ram_OE    = oe_q;
    assign Ram_WE    = we_q;
    assign Ram_Data  = drv_q ? wdata_q : {DW{1'bz}};

endmodule
